// File: rtl/tone_gen_pkg.sv
// tone_gen_pkg: note codes, half-period table and counter width,
// shared by tone_gen and the switch-to-note encoder. Optional: TONE_GEN_OCTAVE_EN.
package tone_gen_pkg;

  localparam int CNT_W = 18;

  typedef logic [3:0]       note_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam note_t N_NONE = 4'd0;
  localparam note_t N_C4   = 4'd1;
  localparam note_t N_D    = 4'd2;
  localparam note_t N_E    = 4'd3;
  localparam note_t N_F    = 4'd4;
  localparam note_t N_G    = 4'd5;
  localparam note_t N_A    = 4'd6;
  localparam note_t N_B    = 4'd7;
  localparam note_t N_C5   = 4'd8;

  // CLK cycles per half-period at 100 MHz
  localparam int HP_C4 = 191110;
  localparam int HP_D  = 170265;
  localparam int HP_E  = 151685;
  localparam int HP_F  = 143172;
  localparam int HP_G  = 127551;
  localparam int HP_A  = 113636;
  localparam int HP_B  = 101239;
  localparam int HP_C5 = 95557;

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  function automatic logic note_valid(input note_t n);
    return (n >= N_C4) && (n <= N_C5);
  endfunction

endpackage

// File: rtl/tone_gen_if.sv
// tone_gen_if: note request in, square-wave and status out.
// Carries octave_up only when TONE_GEN_OCTAVE_EN is defined.
interface tone_gen_if;

  tone_gen_pkg::note_t note;
`ifdef TONE_GEN_OCTAVE_EN
  logic                octave_up;
`endif
  logic                speaker;
  logic                playing;
  tone_gen_pkg::note_t active_note;

  modport master (
`ifdef TONE_GEN_OCTAVE_EN
    output octave_up,
`endif
    output note,
    input  speaker,
    input  playing,
    input  active_note
  );

  modport slave (
`ifdef TONE_GEN_OCTAVE_EN
    input  octave_up,
`endif
    input  note,
    output speaker,
    output playing,
    output active_note
  );

endinterface

// File: rtl/tone_gen_note_to_halfperiod.sv
// note_to_halfperiod: combinational {note[,octave_up]} -> half-period limit.
// Returns 0 for none/invalid codes. Octave shift with TONE_GEN_OCTAVE_EN.
module tone_gen_note_to_halfperiod
  import tone_gen_pkg::*;
#(
  parameter int unsigned HP_DIV = 1
) (
  input  note_t note,
`ifdef TONE_GEN_OCTAVE_EN
  input  logic  octave_up,
`endif
  output cnt_t  limit
);

  // HP_DIV only shrinks the table for fast simulation; 1 in silicon
  localparam cnt_t L_C4 = cnt_t'(HP_C4 / HP_DIV);
  localparam cnt_t L_D  = cnt_t'(HP_D  / HP_DIV);
  localparam cnt_t L_E  = cnt_t'(HP_E  / HP_DIV);
  localparam cnt_t L_F  = cnt_t'(HP_F  / HP_DIV);
  localparam cnt_t L_G  = cnt_t'(HP_G  / HP_DIV);
  localparam cnt_t L_A  = cnt_t'(HP_A  / HP_DIV);
  localparam cnt_t L_B  = cnt_t'(HP_B  / HP_DIV);
  localparam cnt_t L_C5 = cnt_t'(HP_C5 / HP_DIV);

  cnt_t base;

  always_comb begin
    base = '0;
    case (note)
      N_C4:    base = L_C4;
      N_D:     base = L_D;
      N_E:     base = L_E;
      N_F:     base = L_F;
      N_G:     base = L_G;
      N_A:     base = L_A;
      N_B:     base = L_B;
      N_C5:    base = L_C5;
      default: base = '0;
    endcase
  end

`ifdef TONE_GEN_OCTAVE_EN
  assign limit = octave_up ? (base >> 1) : base;
`else
  assign limit = base;
`endif

endmodule

// File: rtl/tone_gen.sv
// tone_gen: glitch-free square-wave synthesiser; note changes land on
// half-period boundaries only. Optional: TONE_GEN_OCTAVE_EN.
module tone_gen
  import tone_gen_pkg::*;
#(
  parameter int unsigned HP_DIV = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  tone_gen_if.slave  io
);

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  cnt_t   limit_q, limit_d;
  note_t  act_q, act_d;
  logic   spk_q, spk_d;
  logic   play_q, play_d;
  logic   oct_q, oct_d;

  cnt_t   lut_limit;
  logic   oct_in;
  logic   valid_in;
  logic   boundary;
  logic   changed;

`ifdef TONE_GEN_OCTAVE_EN
  assign oct_in = io.octave_up;
`else
  assign oct_in = 1'b0;
`endif

  tone_gen_note_to_halfperiod #(
    .HP_DIV    (HP_DIV)
  ) u_lut (
    .note      (io.note),
`ifdef TONE_GEN_OCTAVE_EN
    .octave_up (io.octave_up),
`endif
    .limit     (lut_limit)
  );

  assign valid_in = note_valid(io.note);
  assign boundary = (state_q == PLAY)
                 && (cnt_q == limit_q - cnt_t'(1));
  assign changed  = (io.note != act_q)
                 || (oct_in != oct_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    act_d   = act_q;
    spk_d   = spk_q;
    play_d  = play_q;
    oct_d   = oct_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d = PLAY;
          act_d   = io.note;
          oct_d   = oct_in;
          limit_d = lut_limit;
          cnt_d   = '0;
          spk_d   = 1'b1;
          play_d  = 1'b1;
        end
      end
      PLAY: begin
        if (!boundary) begin
          cnt_d = cnt_q + cnt_t'(1);
        end else if (!valid_in) begin
          // stop always lands low; a low half just ends early
          state_d = IDLE;
          cnt_d   = '0;
          limit_d = '0;
          act_d   = N_NONE;
          oct_d   = 1'b0;
          spk_d   = 1'b0;
          play_d  = 1'b0;
        end else begin
          cnt_d = '0;
          spk_d = ~spk_q;
          if (changed) begin
            act_d   = io.note;
            oct_d   = oct_in;
            limit_d = lut_limit;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      act_q   <= N_NONE;
      spk_q   <= 1'b0;
      play_q  <= 1'b0;
      oct_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      act_q   <= act_d;
      spk_q   <= spk_d;
      play_q  <= play_d;
      oct_q   <= oct_d;
    end
  end

  assign io.speaker     = spk_q;
  assign io.playing     = play_q;
  assign io.active_note = act_q;

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed + random note stimulus against an edge-time model.
// Half-period table is scaled by DIV so the run stays short.
module tb_tone_gen;

  localparam int DIV = 1000;
  localparam int HP_TAB [16] = '{
    0, 191110, 170265, 151685, 143172,
    127551, 113636, 101239, 95557,
    0, 0, 0, 0, 0, 0, 0
  };

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  tone_gen_if io ();

  tone_gen #(
    .HP_DIV (DIV)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .io    (io)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_valid(input int n);
    return (n >= 1) && (n <= 8);
  endfunction

  function automatic int ref_half(input int n, input bit oct);
    int l;
    l = HP_TAB[n] / DIV;
    return oct ? (l >> 1) : l;
  endfunction

  function automatic bit oct_now();
`ifdef TONE_GEN_OCTAVE_EN
    return io.octave_up;
`else
    return 1'b0;
`endif
  endfunction

  // model: playing level, note, and absolute cycle of next boundary
  longint cyc   = 0;
  longint m_end = 0;
  bit     m_play = 0;
  bit     m_spk  = 0;
  int     m_note = 0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_play = 0;
      m_spk  = 0;
      m_note = 0;
    end else begin
      if (!m_play) begin
        if (ref_valid(int'(io.note))) begin
          m_play = 1;
          m_spk  = 1;
          m_note = int'(io.note);
          m_end  = cyc + ref_half(m_note, oct_now());
        end
      end else if (cyc == m_end) begin
        if (!ref_valid(int'(io.note))) begin
          m_play = 0;
          m_spk  = 0;
          m_note = 0;
        end else begin
          m_spk  = !m_spk;
          m_note = int'(io.note);
          m_end  = cyc + ref_half(m_note, oct_now());
        end
      end
      cyc++;
    end
  end

  always @(negedge CLK) begin
    check("spk", int'(io.speaker), int'(m_spk));
    check("play", int'(io.playing), int'(m_play));
    check("act", int'(io.active_note), m_note);
  end

  task automatic wait_edge(output int k);
    logic prev;
    prev = io.speaker;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (io.speaker == prev && k < 1000);
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (io.playing && k < 1000) begin
      @(negedge CLK);
      k++;
    end
  endtask

  int k;
  int nn;

  initial begin
    io.note = 4'd0;
`ifdef TONE_GEN_OCTAVE_EN
    io.octave_up = 1'b0;
`endif
    #1 RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_spk", int'(io.speaker), 0);
    check("rst_play", int'(io.playing), 0);
    check("rst_act", int'(io.active_note), 0);
    RESET = 1'b0;

    io.note = 4'd12;
    repeat (300) @(negedge CLK);
    check("inv_play", int'(io.playing), 0);
    check("inv_spk", int'(io.speaker), 0);

    io.note = 4'd6;
    @(negedge CLK);
    check("a_first", int'(io.speaker), 1);
    check("a_act", int'(io.active_note), 6);
    wait_edge(k);
    check("a_half1", k, 113);
    wait_edge(nn);
    check("a_period", k + nn, 226);

    repeat (40) @(negedge CLK);
    io.note = 4'd1;
    wait_edge(k);
    check("a_finish", 40 + k, 113);
    check("c4_act", int'(io.active_note), 1);
    io.note = 4'd8;
    wait_edge(k);
    check("c4_half", k, 191);

    repeat (30) @(negedge CLK);
    io.note = 4'd0;
    repeat (10) @(negedge CLK);
    io.note = 4'd8;
    wait_edge(k);
    check("c5_glitch", 40 + k, 95);
    wait_edge(k);
    check("c5_half", k, 95);

    io.note = 4'd0;
    wait_idle(k);
    check("stop_bnd", int'(k <= 95), 1);
    check("stop_spk", int'(io.speaker), 0);
    check("stop_act", int'(io.active_note), 0);
    repeat (300) @(negedge CLK);
    check("stay_idle", int'(io.playing), 0);

    io.note = 4'd5;
    repeat (50) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("arst_spk", int'(io.speaker), 0);
    check("arst_play", int'(io.playing), 0);
    check("arst_act", int'(io.active_note), 0);
    io.note = 4'd0;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (200) @(negedge CLK);
    check("post_rst", int'(io.playing), 0);
    io.note = 4'd3;
    @(negedge CLK);
    check("fresh_note", int'(io.speaker), 1);

`ifdef TONE_GEN_OCTAVE_EN
    io.note = 4'd0;
    wait_idle(k);
    io.note = 4'd6;
    io.octave_up = 1'b1;
    @(negedge CLK);
    wait_edge(k);
    check("oct_half", k, 56);
    io.octave_up = 1'b0;
`endif

    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 9) < 7)
        io.note = 4'($urandom_range(1, 8));
      else
        io.note = 4'($urandom_range(0, 15));
`ifdef TONE_GEN_OCTAVE_EN
      io.octave_up = 1'($urandom_range(0, 1));
`endif
      if ($urandom_range(0, 39) == 0) begin
        #2 RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
      end
      repeat ($urandom_range(1, 300)) @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
